edit_seq_ctrl: RTL

Front-panel sequencer for the hex operand editor. Debounces the four edit buttons and a mode button, runs the edit-mode state machine (edit A, edit B, view), and keeps the digit cursor and its blink mask. It issues one-cycle increment/decrement write commands to the 32-bit operand register pair, so the operand registers become a passive datapath.

---
 rtl/edit_seq_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/edit_seq_ctrl.sv
// edit_seq_ctrl: debounced front-panel sequencer for the hex operand editor (mode FSM, cursor, blink, write commands).
// Define AUTOREPEAT_EN to enable autorepeat of digit writes while BTN[2]/BTN[3] is held.
module edit_seq_ctrl #(
  parameter int DEB_CNT     = 50000,
  parameter int BLINK_DIV   = 12500000,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_RATE = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] BTN,
  input  logic       mode_btn,
  output logic [1:0] mode,
  output logic [2:0] cursor,
  output logic [7:0] blink,
  output logic       wr_a,
  output logic       wr_b,
  output logic       wr_dir,
  output logic [2:0] wr_digit
);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int BW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {EDIT_A = 2'b00, EDIT_B = 2'b01, VIEW = 2'b10} mode_t;

  logic [4:0] raw_in, deb_lvl, ev;
  assign raw_in = {mode_btn, BTN};

  // Bit 4 is the mode button, bits 3:0 the edit buttons.
  for (genvar gi = 0; gi < 5; gi++) begin : g_deb
    logic s1_q, s1_d, s2_q, s2_d, lvl_q, lvl_d, ev_q, ev_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
      s1_d  = raw_in[gi];
      s2_d  = s1_q;
      lvl_d = lvl_q;
      cnt_d = '0;
      if (s2_q != lvl_q) begin
        if (cnt_q == DW'(DEB_CNT)) lvl_d = s2_q;
        else                       cnt_d = cnt_q + DW'(1);
      end
      ev_d = lvl_d & ~lvl_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q  <= 1'b0;
        s2_q  <= 1'b0;
        lvl_q <= 1'b0;
        ev_q  <= 1'b0;
        cnt_q <= '0;
      end else begin
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        lvl_q <= lvl_d;
        ev_q  <= ev_d;
        cnt_q <= cnt_d;
      end
    end

    assign deb_lvl[gi] = lvl_q;
    assign ev[gi]      = ev_q;
  end

  mode_t         mode_q, mode_d;
  logic [2:0]    cursor_q, cursor_d, wr_digit_q, wr_digit_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d, wr_a_q, wr_a_d, wr_b_q, wr_b_d, wr_dir_q, wr_dir_d;
  logic          mode_ev, cur_ev, in_edit, dig_fire, restart, rpt_fire, rpt_dir;

  assign mode_ev = ev[4];
  assign cur_ev  = ev[0] | ev[1];
  assign in_edit = (mode_q != VIEW);

  always_comb begin
    mode_d   = mode_q;
    cursor_d = cursor_q;
    phase_d  = phase_q;
    dig_fire = 1'b0;
    restart  = 1'b0;
    if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + BW'(1);
    end
    // Mode beats cursor beats digit; an opposing pair of events cancels itself.
    if (mode_ev) begin
      restart = 1'b1;
      case (mode_q)
        EDIT_A:  mode_d = EDIT_B;
        EDIT_B:  mode_d = VIEW;
        default: mode_d = EDIT_A;
      endcase
    end else if (cur_ev) begin
      if (in_edit && (ev[0] != ev[1])) begin
        restart  = 1'b1;
        cursor_d = ev[0] ? cursor_q + 3'd1 : cursor_q - 3'd1;
      end
    end else if (in_edit && (ev[2] != ev[3])) begin
      dig_fire = 1'b1;
    end
    if (restart) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);

  logic          rpt_on_q, rpt_on_d, rpt_first_q, rpt_first_d, hold_ok, unused_lvl;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d, rpt_lim;

  assign unused_lvl = ^{deb_lvl[4], deb_lvl[1:0]};
  assign hold_ok    = (deb_lvl[2] ^ deb_lvl[3]) && in_edit && !mode_ev && !cur_ev;
  assign rpt_lim    = rpt_first_q ? RW'(REPEAT_DLY - 1) : RW'(REPEAT_RATE - 1);
  assign rpt_dir    = deb_lvl[2];

  always_comb begin
    rpt_on_d    = 1'b0;
    rpt_first_d = rpt_first_q;
    rpt_cnt_d   = '0;
    rpt_fire    = 1'b0;
    if (dig_fire) begin
      rpt_on_d    = 1'b1;
      rpt_first_d = 1'b1;
    end else if (rpt_on_q && hold_ok) begin
      rpt_on_d = 1'b1;
      if (rpt_cnt_q == rpt_lim) begin
        rpt_fire    = 1'b1;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_on_q    <= 1'b0;
      rpt_first_q <= 1'b0;
      rpt_cnt_q   <= '0;
    end else begin
      rpt_on_q    <= rpt_on_d;
      rpt_first_q <= rpt_first_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{deb_lvl, REPEAT_DLY[0], REPEAT_RATE[0]};
  assign rpt_fire   = 1'b0;
  assign rpt_dir    = 1'b0;
`endif

  // The digit index is the cursor registered before this edge.
  always_comb begin
    wr_a_d     = 1'b0;
    wr_b_d     = 1'b0;
    wr_dir_d   = wr_dir_q;
    wr_digit_d = wr_digit_q;
    if (dig_fire || rpt_fire) begin
      wr_a_d     = (mode_q == EDIT_A);
      wr_b_d     = (mode_q == EDIT_B);
      wr_dir_d   = dig_fire ? ev[2] : rpt_dir;
      wr_digit_d = cursor_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= EDIT_A;
      cursor_q   <= 3'd0;
      bcnt_q     <= '0;
      phase_q    <= 1'b1;
      wr_a_q     <= 1'b0;
      wr_b_q     <= 1'b0;
      wr_dir_q   <= 1'b0;
      wr_digit_q <= 3'd0;
    end else begin
      mode_q     <= mode_d;
      cursor_q   <= cursor_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      wr_a_q     <= wr_a_d;
      wr_b_q     <= wr_b_d;
      wr_dir_q   <= wr_dir_d;
      wr_digit_q <= wr_digit_d;
    end
  end

  assign mode     = mode_q;
  assign cursor   = cursor_q;
  assign blink    = (in_edit && phase_q) ? (8'b1 << cursor_q) : 8'h00;
  assign wr_a     = wr_a_q;
  assign wr_b     = wr_b_q;
  assign wr_dir   = wr_dir_q;
  assign wr_digit = wr_digit_q;
endmodule
